// File: rtl/obi_arb_pkg.sv
// Shared types and defaults for the two-requester OBI memory arbiter.
package obi_arb_pkg;

    typedef enum logic {
        REQ_CORE = 1'b0,
        REQ_DBG  = 1'b1
    } req_id_e;

    localparam int unsigned MAX_OUTSTANDING_DEFAULT = 2;

endpackage

// File: rtl/obi_arb_id_fifo.sv
// Circular FIFO of requester IDs; one entry per granted, unanswered transaction.
module obi_arb_id_fifo
    import obi_arb_pkg::*;
#(
    parameter int unsigned DEPTH = MAX_OUTSTANDING_DEFAULT
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       push_i,
    input  req_id_e                    push_id_i,
    input  logic                       pop_i,
    output req_id_e                    head_id_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    req_id_e          ids_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok, pop_ok;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
    endfunction

    assign full_o    = (count_q == CNT_W'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign push_ok   = push_i & ~full_o;
    assign pop_ok    = pop_i & ~empty_o;
    assign head_id_o = ids_q[rd_ptr_q];
    assign count_o   = count_q;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = ptr_inc(wr_ptr_q);
        if (pop_ok)  rd_ptr_d = ptr_inc(rd_ptr_q);
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is not reset; an entry is only read after it was written, gated by count.
    always_ff @(posedge clk_i) begin
        if (push_ok) ids_q[wr_ptr_q] <= push_id_i;
    end

endmodule

// File: rtl/obi_mem_arbiter.sv
// Round-robin arbiter sharing one OBI memory port between the core data port (m0) and debug bus (m1).
module obi_mem_arbiter
    import obi_arb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned MAX_OUTSTANDING = MAX_OUTSTANDING_DEFAULT
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic                                 m0_req_i,
    output logic                                 m0_gnt_o,
    input  logic [ADDR_WIDTH-1:0]                m0_addr_i,
    input  logic                                 m0_we_i,
    input  logic [DATA_WIDTH/8-1:0]              m0_be_i,
    input  logic [DATA_WIDTH-1:0]                m0_wdata_i,
    output logic                                 m0_rvalid_o,
    output logic [DATA_WIDTH-1:0]                m0_rdata_o,
    input  logic                                 m1_req_i,
    output logic                                 m1_gnt_o,
    input  logic [ADDR_WIDTH-1:0]                m1_addr_i,
    input  logic                                 m1_we_i,
    input  logic [DATA_WIDTH/8-1:0]              m1_be_i,
    input  logic [DATA_WIDTH-1:0]                m1_wdata_i,
    output logic                                 m1_rvalid_o,
    output logic [DATA_WIDTH-1:0]                m1_rdata_o,
    output logic                                 mem_req_o,
    output logic [ADDR_WIDTH-1:0]                mem_addr_o,
    output logic                                 mem_we_o,
    output logic [DATA_WIDTH/8-1:0]              mem_be_o,
    output logic [DATA_WIDTH-1:0]                mem_wdata_o,
    input  logic                                 mem_gnt_i,
    input  logic                                 mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0]                mem_rdata_i,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o,
    output logic                                 err_o
);

    req_id_e sel, last_q, last_d, lock_id_q, lock_id_d, head_id;
    logic    lock_q, lock_d, err_q, err_d;
    logic    lock_drop, sel_req, gnt, rsp_valid, fifo_full, fifo_empty;

    // A held lock wins while its owner keeps requesting; otherwise plain round-robin.
    always_comb begin
        sel       = REQ_CORE;
        lock_drop = 1'b0;
        if (lock_q && ((lock_id_q == REQ_CORE) ? m0_req_i : m1_req_i)) begin
            sel = lock_id_q;
        end else begin
            lock_drop = lock_q;
            if (m0_req_i && m1_req_i) sel = (last_q == REQ_CORE) ? REQ_DBG : REQ_CORE;
            else if (m1_req_i)        sel = REQ_DBG;
            else                      sel = REQ_CORE;
        end
    end

    assign sel_req     = (sel == REQ_CORE) ? m0_req_i   : m1_req_i;
    assign mem_addr_o  = (sel == REQ_CORE) ? m0_addr_i  : m1_addr_i;
    assign mem_we_o    = (sel == REQ_CORE) ? m0_we_i    : m1_we_i;
    assign mem_be_o    = (sel == REQ_CORE) ? m0_be_i    : m1_be_i;
    assign mem_wdata_o = (sel == REQ_CORE) ? m0_wdata_i : m1_wdata_i;

    assign mem_req_o = sel_req & ~fifo_full;
    assign gnt       = mem_req_o & mem_gnt_i;
    assign m0_gnt_o  = gnt & (sel == REQ_CORE);
    assign m1_gnt_o  = gnt & (sel == REQ_DBG);

    // Responses come back in grant order, so the FIFO head names the owner.
    assign rsp_valid   = mem_rvalid_i & ~fifo_empty;
    assign m0_rvalid_o = rsp_valid & (head_id == REQ_CORE);
    assign m1_rvalid_o = rsp_valid & (head_id == REQ_DBG);
    assign m0_rdata_o  = m0_rvalid_o ? mem_rdata_i : '0;
    assign m1_rdata_o  = m1_rvalid_o ? mem_rdata_i : '0;
    assign err_o       = err_q;

    always_comb begin
        lock_d    = mem_req_o & ~mem_gnt_i;
        lock_id_d = sel;
        last_d    = gnt ? sel : last_q;
        err_d     = err_q | lock_drop | (mem_rvalid_i & fifo_empty);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lock_q    <= 1'b0;
            lock_id_q <= REQ_CORE;
            last_q    <= REQ_DBG;
            err_q     <= 1'b0;
        end else begin
            lock_q    <= lock_d;
            lock_id_q <= lock_id_d;
            last_q    <= last_d;
            err_q     <= err_d;
        end
    end

    obi_arb_id_fifo #(
        .DEPTH(MAX_OUTSTANDING)
    ) u_id_fifo (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .push_i   (gnt),
        .push_id_i(sel),
        .pop_i    (mem_rvalid_i),
        .head_id_o(head_id),
        .full_o   (fifo_full),
        .empty_o  (fifo_empty),
        .count_o  (outstanding_o)
    );

endmodule

// File: tb/tb_obi_mem_arbiter.sv
// Self-checking bench for obi_mem_arbiter: directed cycles plus an in-order response scoreboard.
module tb_obi_mem_arbiter;

    localparam logic [31:0] A0 = 32'h0000_0100;
    localparam logic [31:0] A1 = 32'h0000_0200;
    localparam logic [31:0] W0 = 32'h1111_0000;
    localparam logic [31:0] W1 = 32'h2222_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        m0_req = 1'b0, m1_req = 1'b0, m0_we = 1'b1, m1_we = 1'b0;
    logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic        mem_req, mem_we, mem_gnt = 1'b0, mem_rvalid = 1'b0;
    logic [31:0] mem_addr, mem_wdata, mem_rdata = '0;
    logic [3:0]  mem_be;
    logic [1:0]  outstanding;
    logic        err;

    int total = 0;
    int bad = 0;
    int sb[$];
    logic exp_err = 1'b0;

    always #5 clk = ~clk;

    obi_mem_arbiter dut (
        .clk_i(clk), .rst_ni(rst_n),
        .m0_req_i(m0_req), .m0_gnt_o(m0_gnt), .m0_addr_i(A0), .m0_we_i(m0_we),
        .m0_be_i(4'hF), .m0_wdata_i(W0), .m0_rvalid_o(m0_rvalid), .m0_rdata_o(m0_rdata),
        .m1_req_i(m1_req), .m1_gnt_o(m1_gnt), .m1_addr_i(A1), .m1_we_i(m1_we),
        .m1_be_i(4'h3), .m1_wdata_i(W1), .m1_rvalid_o(m1_rvalid), .m1_rdata_o(m1_rdata),
        .mem_req_o(mem_req), .mem_addr_o(mem_addr), .mem_we_o(mem_we), .mem_be_o(mem_be),
        .mem_wdata_o(mem_wdata), .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid),
        .mem_rdata_i(mem_rdata), .outstanding_o(outstanding), .err_o(err)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Asserts reset asynchronously mid-cycle, checks the immediate effect, releases after two edges.
    task automatic do_reset();
        rst_n = 1'b0;
        m0_req = 1'b0; m1_req = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
        #1;
        check("rst_outstanding", outstanding, 0);
        check("rst_err", err, 0);
        check("rst_mem_req", mem_req, 0);
        sb.delete();
        exp_err = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // One clock: drive, check combinational outputs, then advance. exp_sel = -1 means no memory request.
    task automatic cycle(input logic r0, input logic r1, input logic g, input logic rv,
                         input logic [31:0] rd, input int exp_sel);
        int id;
        m0_req = r0; m1_req = r1; mem_gnt = g; mem_rvalid = rv; mem_rdata = rd;
        #1;
        check("outstanding", outstanding, sb.size());
        check("err", err, exp_err);
        check("mem_req", mem_req, exp_sel >= 0);
        if (exp_sel >= 0) begin
            check("mem_addr", mem_addr, (exp_sel == 0) ? A0 : A1);
            check("mem_we", mem_we, (exp_sel == 0) ? m0_we : m1_we);
            check("mem_wdata", mem_wdata, (exp_sel == 0) ? W0 : W1);
        end
        check("m0_gnt", m0_gnt, g && exp_sel == 0);
        check("m1_gnt", m1_gnt, g && exp_sel == 1);
        if (rv) begin
            if (sb.size() > 0) begin
                id = sb.pop_front();
                check("m0_rvalid", m0_rvalid, id == 0);
                check("m1_rvalid", m1_rvalid, id == 1);
                check("m0_rdata", m0_rdata, (id == 0) ? rd : 32'h0);
                check("m1_rdata", m1_rdata, (id == 1) ? rd : 32'h0);
            end else begin
                check("stray_m0_rvalid", m0_rvalid, 0);
                check("stray_m1_rvalid", m1_rvalid, 0);
                exp_err = 1'b1;
            end
        end else begin
            check("idle_rvalid", {m1_rvalid, m0_rvalid}, 0);
        end
        if (g && exp_sel >= 0) sb.push_back(exp_sel);
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Alternating round-robin with a response every cycle (push and pop together).
        do_reset();
        cycle(1, 1, 1, 0, 32'h0, 0);
        for (int i = 1; i <= 6; i++) cycle(1, 1, 1, 1, $urandom, i % 2);
        cycle(0, 0, 0, 1, $urandom, -1);

        // Lock holds m1 while memory stalls, even after m0 starts requesting.
        do_reset();
        cycle(0, 1, 0, 0, 32'h0, 1);
        cycle(1, 1, 0, 0, 32'h0, 1);
        cycle(1, 1, 0, 0, 32'h0, 1);
        cycle(1, 1, 1, 0, 32'h0, 1);
        cycle(1, 0, 1, 0, 32'h0, 0);
        cycle(0, 0, 0, 1, 32'h5A5A, -1);
        cycle(0, 0, 0, 1, 32'hA5A5, -1);

        // Full FIFO blocks requests until a response pops.
        do_reset();
        cycle(1, 0, 1, 0, 32'h0, 0);
        cycle(1, 0, 1, 0, 32'h0, 0);
        cycle(1, 0, 1, 0, 32'h0, -1);
        cycle(1, 0, 1, 1, 32'h1234, -1);
        cycle(1, 0, 1, 0, 32'h0, 0);
        cycle(0, 0, 0, 1, 32'h5678, -1);
        cycle(0, 0, 0, 1, 32'h9ABC, -1);

        // In-order read responses routed to their owners.
        do_reset();
        m0_we = 1'b0;
        cycle(1, 0, 1, 0, 32'h0, 0);
        cycle(0, 1, 1, 0, 32'h0, 1);
        cycle(0, 0, 0, 1, 32'hAAAA, -1);
        cycle(0, 0, 0, 1, 32'hBBBB, -1);
        m0_we = 1'b1;

        // Stray response with nothing outstanding: sticky error.
        do_reset();
        cycle(0, 0, 0, 1, 32'hDEAD, -1);
        cycle(0, 0, 0, 0, 32'h0, -1);
        cycle(1, 0, 1, 0, 32'h0, 0);
        cycle(0, 0, 0, 1, 32'h7777, -1);

        // Locked requester dropping its request releases the lock and flags an error.
        do_reset();
        cycle(0, 1, 0, 0, 32'h0, 1);
        cycle(1, 0, 0, 0, 32'h0, 0);
        exp_err = 1'b1;
        cycle(1, 0, 1, 0, 32'h0, 0);
        cycle(0, 0, 0, 1, 32'h4444, -1);

        // Reset with two in flight, late response afterwards, and first tie to m0.
        do_reset();
        cycle(1, 0, 1, 0, 32'h0, 0);
        cycle(1, 0, 1, 0, 32'h0, 0);
        do_reset();
        cycle(0, 0, 0, 1, 32'hBEEF, -1);
        cycle(1, 1, 1, 0, 32'h0, 0);
        cycle(1, 1, 1, 0, 32'h0, 1);
        cycle(0, 0, 0, 1, 32'h0F0F, -1);
        cycle(0, 0, 0, 1, 32'hF0F0, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
